// File: rtl/accel_dispatch_ctrl_if.sv
// Signal bundle between the pipeline's EXE/MEM and MEM/WB stages, the three crypto
// engines, and the accelerator dispatch controller.
interface accel_dispatch_ctrl_if;
    logic       mem_ntt_start, mem_pwam_start, mem_keccak_start;
    logic       mem_ntt_we, mem_pwam_wea, mem_pwam_web, mem_keccak_we;
    logic       wb_ntt_start, wb_pwam_start, wb_keccak_start;
    logic       ntt_done, pwam_done, keccak_done;
    logic       ntt_req, pwam_req, keccak_req;
    logic       err_clr;
    logic       ntt_go, pwam_go, keccak_go;
    logic       memwb_ce, pipe_stall;
    logic [2:0] dmem_grant, busy, err;

    modport master (
        output mem_ntt_start, mem_pwam_start, mem_keccak_start,
               mem_ntt_we, mem_pwam_wea, mem_pwam_web, mem_keccak_we,
               wb_ntt_start, wb_pwam_start, wb_keccak_start,
               ntt_done, pwam_done, keccak_done,
               ntt_req, pwam_req, keccak_req, err_clr,
        input  ntt_go, pwam_go, keccak_go, memwb_ce, pipe_stall,
               dmem_grant, busy, err
    );

    modport slave (
        input  mem_ntt_start, mem_pwam_start, mem_keccak_start,
               mem_ntt_we, mem_pwam_wea, mem_pwam_web, mem_keccak_we,
               wb_ntt_start, wb_pwam_start, wb_keccak_start,
               ntt_done, pwam_done, keccak_done,
               ntt_req, pwam_req, keccak_req, err_clr,
        output ntt_go, pwam_go, keccak_go, memwb_ce, pipe_stall,
               dmem_grant, busy, err
    );
endinterface

// File: rtl/accel_dispatch_ctrl.sv
// Launches and tracks the NTT/PWAM/Keccak engines, stalls the pipeline on busy-engine
// hazards, and round-robin arbitrates the shared DMEM port.
module accel_dispatch_ctrl #(
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    accel_dispatch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_ERR} eng_state_e;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    eng_state_e      st     [3];
    eng_state_e      st_nxt [3];
    logic [TO_W-1:0] cnt     [3];
    logic [TO_W-1:0] cnt_nxt [3];

    logic [2:0] wb_start, done_v, req_v, mem_hit;
    logic [2:0] busy_v, go_v, err_v;
    logic [2:0] grant, grant_nxt;
    logic [1:0] last, last_nxt;
    logic       hz;

    // Vectors are ordered {keccak, pwam, ntt}; PWAM has two CPU write ports.
    assign wb_start = {bus.wb_keccak_start, bus.wb_pwam_start, bus.wb_ntt_start};
    assign done_v   = {bus.keccak_done, bus.pwam_done, bus.ntt_done};
    assign req_v    = {bus.keccak_req, bus.pwam_req, bus.ntt_req};
    assign mem_hit  = {bus.mem_keccak_start | bus.mem_keccak_we,
                       bus.mem_pwam_start | bus.mem_pwam_wea | bus.mem_pwam_web,
                       bus.mem_ntt_start | bus.mem_ntt_we};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                st[i]  <= S_IDLE;
                cnt[i] <= '0;
            end
            grant <= '0;
            last  <= 2'd2;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                st[i]  <= st_nxt[i];
                cnt[i] <= cnt_nxt[i];
            end
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // A done in the same cycle as the timeout boundary takes precedence over the timeout.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            st_nxt[i]  = st[i];
            cnt_nxt[i] = cnt[i];
            unique case (st[i])
                S_IDLE: begin
                    if (wb_start[i]) st_nxt[i] = S_LAUNCH;
                end
                S_LAUNCH: begin
                    st_nxt[i]  = S_BUSY;
                    cnt_nxt[i] = '0;
                end
                S_BUSY: begin
                    cnt_nxt[i] = cnt[i] + TO_ONE;
                    if (done_v[i]) begin
                        st_nxt[i] = S_IDLE;
                    end else if ((TIMEOUT != 0) && (cnt_nxt[i] == TO_LIM)) begin
                        st_nxt[i] = S_ERR;
                    end
                end
                S_ERR: begin
                    if (bus.err_clr) st_nxt[i] = S_IDLE;
                end
                default: st_nxt[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_v = '0;
        go_v   = '0;
        err_v  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            busy_v[i] = (st[i] != S_IDLE);
            go_v[i]   = (st[i] == S_LAUNCH);
            err_v[i]  = (st[i] == S_ERR);
        end
    end

    function automatic logic [1:0] rr_pick(input logic [1:0] from, input int unsigned step);
        int unsigned s;
        s = (32'(from) + step) % 3;
        return s[1:0];
    endfunction

    // Grant is only recomputed from an empty port, giving one idle cycle between owners.
    always_comb begin
        grant_nxt = '0;
        last_nxt  = last;
        if (grant != '0) begin
            if ((grant & req_v) != '0) grant_nxt = grant;
        end else begin
            for (int unsigned k = 1; k <= 3; k++) begin
                if ((grant_nxt == '0) && req_v[rr_pick(last, k)]) begin
                    grant_nxt[rr_pick(last, k)] = 1'b1;
                    last_nxt                    = rr_pick(last, k);
                end
            end
        end
    end

    assign hz = |(mem_hit & busy_v);

    assign bus.ntt_go     = go_v[0];
    assign bus.pwam_go    = go_v[1];
    assign bus.keccak_go  = go_v[2];
    assign bus.busy       = busy_v;
    assign bus.err        = err_v;
    assign bus.dmem_grant = grant;
    assign bus.pipe_stall = hz;
    assign bus.memwb_ce   = ~hz;
endmodule

// File: tb/tb_accel_dispatch_ctrl.sv
// Bench for accel_dispatch_ctrl: two instances (long and short timeout) driven in lockstep
// and compared every cycle against an age-based behavioural model.
module tb_accel_dispatch_ctrl;
    localparam int unsigned TMO_A = 40;
    localparam int unsigned TMO_B = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] mstart = '0, mwe = '0, wbs = '0, done = '0, req = '0;
    logic pwam_web = 1'b0, err_clr = 1'b0;

    logic [2:0] o_go [2];
    logic [2:0] o_busy [2];
    logic [2:0] o_err [2];
    logic [2:0] o_grant [2];
    logic       o_stall [2];
    logic       o_ce [2];

    int total = 0;
    int bad   = 0;

    // Model: age -1 idle, 0 launch cycle, n>=1 the n-th busy cycle; errf marks the error state.
    int age [2][3];
    bit errf [2][3];
    int owner [2];
    int last [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        accel_dispatch_ctrl_if bus ();
        assign bus.mem_ntt_start    = mstart[0];
        assign bus.mem_pwam_start   = mstart[1];
        assign bus.mem_keccak_start = mstart[2];
        assign bus.mem_ntt_we       = mwe[0];
        assign bus.mem_pwam_wea     = mwe[1];
        assign bus.mem_pwam_web     = pwam_web;
        assign bus.mem_keccak_we    = mwe[2];
        assign bus.wb_ntt_start     = wbs[0];
        assign bus.wb_pwam_start    = wbs[1];
        assign bus.wb_keccak_start  = wbs[2];
        assign bus.ntt_done         = done[0];
        assign bus.pwam_done        = done[1];
        assign bus.keccak_done      = done[2];
        assign bus.ntt_req          = req[0];
        assign bus.pwam_req         = req[1];
        assign bus.keccak_req       = req[2];
        assign bus.err_clr          = err_clr;

        accel_dispatch_ctrl #(.TO_W(16), .TIMEOUT(g == 0 ? TMO_A : TMO_B)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        assign o_go[g]    = {bus.keccak_go, bus.pwam_go, bus.ntt_go};
        assign o_busy[g]  = bus.busy;
        assign o_err[g]   = bus.err;
        assign o_grant[g] = bus.dmem_grant;
        assign o_stall[g] = bus.pipe_stall;
        assign o_ce[g]    = bus.memwb_ce;
    end

    task automatic chk(input string tag, input int d, input logic [2:0] obs, input logic [2:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, d, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int tmo(input int d);
        return (d == 0) ? int'(TMO_A) : int'(TMO_B);
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                age[d][i]  = -1;
                errf[d][i] = 1'b0;
            end
            owner[d] = -1;
            last[d]  = 2;
        end
    endfunction

    function automatic void m_update();
        if (!rst) begin
            m_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                if (errf[d][i]) begin
                    if (err_clr) begin
                        errf[d][i] = 1'b0;
                        age[d][i]  = -1;
                    end
                end else if (age[d][i] < 0) begin
                    if (wbs[i]) age[d][i] = 0;
                end else if (age[d][i] == 0) begin
                    age[d][i] = 1;
                end else if (done[i]) begin
                    age[d][i] = -1;
                end else if (tmo(d) != 0 && age[d][i] == tmo(d)) begin
                    errf[d][i] = 1'b1;
                end else begin
                    age[d][i]++;
                end
            end
            if (owner[d] >= 0) begin
                if (req[owner[d]] == 1'b0) owner[d] = -1;
            end else begin
                bit found;
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    int j;
                    j = (last[d] + k) % 3;
                    if (!found && req[j]) begin
                        found    = 1'b1;
                        owner[d] = j;
                        last[d]  = j;
                    end
                end
            end
        end
    endfunction

    task automatic at_neg();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic [2:0] eg, eb, ee, egr, hit;
            logic es;
            eg = '0;
            eb = '0;
            ee = '0;
            for (int i = 0; i < 3; i++) begin
                eb[i] = (age[d][i] >= 0);
                eg[i] = (age[d][i] == 0) && !errf[d][i];
                ee[i] = errf[d][i];
            end
            egr = (owner[d] >= 0) ? 3'(1 << owner[d]) : 3'b000;
            hit = {mstart[2] | mwe[2], mstart[1] | mwe[1] | pwam_web, mstart[0] | mwe[0]};
            es  = |(hit & eb);
            chk("go", d, o_go[d], eg);
            chk("busy", d, o_busy[d], eb);
            chk("err", d, o_err[d], ee);
            chk("grant", d, o_grant[d], egr);
            chk("stall", d, {2'b00, o_stall[d]}, {2'b00, es});
            chk("memwb_ce", d, {2'b00, o_ce[d]}, {2'b00, ~es});
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic tick();
        at_neg();
        at_pos();
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        int go_cnt, busy_cnt, ce_low, stall_cnt;
        int gc [3];
        int order [$];
        int gaps [$];
        int idle_run;
        logic [2:0] prev;

        m_reset();
        // Reset state, then release
        tick();
        rst = 1'b1;

        // NTT launch, done 10 cycles after go
        wbs = 3'b001;
        tick();
        wbs = '0;
        go_cnt = 0; busy_cnt = 0; ce_low = 0;
        for (int k = 0; k < 15; k++) begin
            done[0] = (k == 10);
            at_neg();
            go_cnt   += int'(o_go[0][0]);
            busy_cnt += int'(o_busy[0][0]);
            ce_low   += int'(!o_ce[0]);
            at_pos();
        end
        done = '0;
        chk_int("ntt_go_cycles", go_cnt, 1);
        chk_int("ntt_busy_cycles", busy_cnt, 11);
        chk_int("ntt_ce_low_cycles", ce_low, 0);
        clear_errs();

        // CPU write to a busy NTT stalls until done
        wbs = 3'b001;
        tick();
        wbs = '0;
        mwe[0] = 1'b1;
        stall_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            done[0] = (k == 20);
            at_neg();
            stall_cnt += int'(o_stall[0]);
            at_pos();
        end
        done = '0;
        mwe = '0;
        chk_int("ntt_stall_cycles", stall_cnt, 21);
        clear_errs();

        // Keccak timeout on the short-timeout instance
        wbs = 3'b100;
        tick();
        wbs = '0;
        for (int k = 0; k < 12; k++) tick();
        chk("keccak_timeout_err", 1, o_err[1], 3'b100);
        chk("keccak_timeout_busy", 1, o_busy[1], 3'b100);
        chk("keccak_long_busy", 0, o_busy[0], 3'b100);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("errclr_err", 1, o_err[1], 3'b000);
        chk("errclr_busy", 1, o_busy[1], 3'b000);
        done = 3'b100;
        tick();
        done = '0;
        tick();

        // Round robin with all three requesters
        for (int j = 0; j < 3; j++) gc[j] = 0;
        prev = '0;
        idle_run = 0;
        req = 3'b111;
        for (int c = 0; c < 12; c++) begin
            at_neg();
            if (o_grant[0] != '0) begin
                if (o_grant[0] != prev) begin
                    order.push_back(o_grant[0] == 3'b001 ? 0 : (o_grant[0] == 3'b010 ? 1 : 2));
                    if (order.size() > 1) gaps.push_back(idle_run);
                end
                idle_run = 0;
                for (int j = 0; j < 3; j++) begin
                    if (o_grant[0][j]) begin
                        gc[j]++;
                        if (gc[j] == 2) req[j] = 1'b0;
                    end
                end
            end else begin
                idle_run++;
            end
            prev = o_grant[0];
            at_pos();
        end
        req = '0;
        chk_int("rr_owner_count", order.size(), 3);
        if (order.size() == 3) begin
            chk_int("rr_first", order[0], 0);
            chk_int("rr_second", order[1], 1);
            chk_int("rr_third", order[2], 2);
        end
        if (gaps.size() == 2) begin
            chk_int("rr_gap0", gaps[0], 1);
            chk_int("rr_gap1", gaps[1], 1);
        end else begin
            chk_int("rr_gap_count", gaps.size(), 2);
        end

        // ntt re-request after release loses to waiting pwam
        req = 3'b001;
        tick();
        tick();
        chk("ntt_owns", 0, o_grant[0], 3'b001);
        req = 3'b010;
        tick();
        req = 3'b011;
        tick();
        chk("pwam_before_ntt", 0, o_grant[0], 3'b010);
        chk("pwam_before_ntt", 1, o_grant[1], 3'b010);
        req = '0;
        tick();
        tick();

        // Asynchronous reset during PWAM busy with grant held
        wbs = 3'b010;
        tick();
        wbs = '0;
        req = 3'b010;
        for (int k = 0; k < 3; k++) tick();
        chk("pre_reset_grant", 0, o_grant[0], 3'b010);
        #3;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_busy", d, o_busy[d], 3'b000);
            chk("async_err", d, o_err[d], 3'b000);
            chk("async_grant", d, o_grant[d], 3'b000);
        end
        m_reset();
        req = '0;
        tick();
        rst = 1'b1;
        wbs = 3'b010;
        tick();
        wbs = '0;
        at_neg();
        chk("relaunch_go", 0, o_go[0], 3'b010);
        at_pos();
        done = 3'b010;
        tick();
        done = '0;

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                wbs[i]    = ($urandom_range(7) == 0);
                mstart[i] = ($urandom_range(3) == 0);
                mwe[i]    = ($urandom_range(3) == 0);
                done[i]   = ($urandom_range(5) == 0);
                if ($urandom_range(4) == 0) req[i] = ~req[i];
            end
            pwam_web = ($urandom_range(3) == 0);
            err_clr  = ($urandom_range(15) == 0);
            tick();
        end
        mstart = '0; mwe = '0; wbs = '0; done = '0; req = '0;
        pwam_web = 1'b0; err_clr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
